// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package  : imem_loader_pkg
// Brief    : Shared constants, state encodings and helpers for the
//            instruction-memory boot loader.
// Config   : IMEM_LOADER_CHECKSUM_EN (CHK state is encoded unconditionally)
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Default instruction-memory word-address width (DEPTH = 2**width)
    localparam int c_default_addr_width = 8;

    // Number of header bytes carrying the little-endian word count
    localparam int c_hdr_len = 2;

    // Loader state encoding
    localparam int c_state_w = 3;
    typedef logic [c_state_w-1:0] state_t;

    localparam state_t c_st_idle = 3'd0;
    localparam state_t c_st_hdr0 = 3'd1;
    localparam state_t c_st_hdr1 = 3'd2;
    localparam state_t c_st_data = 3'd3;
    localparam state_t c_st_fin  = 3'd4;
    localparam state_t c_st_chk  = 3'd5;
    localparam state_t c_st_done = 3'd6;

    // Memory depth in words, sized to compare against a 16-bit count
    function automatic logic [16:0] depth_words(input int aw);
        return 17'(1) << aw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Interface: imem_loader_if
// Brief    : Byte-stream input handshake plus instruction-memory write bus.
//            'master' is the image source / memory side, 'slave' the loader.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = c_default_addr_width
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : imem_byte_assembler
// Brief    : Packs four accepted bytes into a little-endian 32-bit word and
//            strobes once per completed word; optionally keeps a running XOR
//            of every header/data byte.
// Config   : IMEM_LOADER_CHECKSUM_EN adds the XOR accumulator ports.
// Revision : 1.0 - initial release
// ============================================================================
module imem_byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_data_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic        o_last_byte
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    input  logic        i_acc_en,
    output logic [7:0]  o_acc
`endif
);

    logic [1:0]  r_idx;
    logic [31:0] r_word;
    logic        r_word_valid;

    // Byte slot selection, word assembly and one-cycle word-complete strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= 2'd0;
            r_word       <= 32'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= i_data_en && (r_idx == 2'd3);
            if (i_clear) begin
                r_idx <= 2'd0;
            end else if (i_data_en) begin
                r_idx                        <= r_idx + 2'd1;
                r_word[{r_idx, 3'b000} +: 8] <= i_byte;
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_last_byte  = (r_idx == 2'd3);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_acc;

    // Running XOR over header and data bytes, restarted with each load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 8'd0;
        end else if (i_clear) begin
            r_acc <= 8'd0;
        end else if (i_acc_en) begin
            r_acc <= r_acc ^ i_byte;
        end
    end

    assign o_acc = r_acc;
`endif

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Boot-time program loader. Parses a 16-bit little-endian word
//            count, assembles little-endian instructions from a byte stream,
//            writes them to consecutive instruction-memory words and holds the
//            core in reset until the image has loaded successfully.
// Config   : IMEM_LOADER_CHECKSUM_EN - trailing XOR checksum byte (CHK state).
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = c_default_addr_width
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         core_reset,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam logic [16:0] c_depth = depth_words(ADDR_WIDTH);

    // State that follows the last data word (or an empty image)
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t c_st_tail = c_st_chk;
`else
    localparam state_t c_st_tail = c_st_fin;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_count;
    logic [16:0] r_word_idx;
    logic        r_error;

    logic        w_accept;
    logic        w_start_load;
    logic [16:0] w_count_new;
    logic        w_oversize;
    logic        w_empty;
    logic        w_last_word;
    logic        w_last_byte;
    logic        w_data_en;
    logic        w_word_valid;
    logic [31:0] w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic        w_acc_en;
    logic [7:0]  w_acc;
`endif

    assign w_accept     = bus.in_valid && bus.in_ready;
    // start only matters when no load is in progress
    assign w_start_load = start && ((r_state == c_st_idle) || (r_state == c_st_done));
    // Full count as it will be once the high header byte lands
    assign w_count_new  = {1'b0, bus.in_data, r_count[7:0]};
    assign w_oversize   = (w_count_new > c_depth);
    assign w_empty      = (w_count_new == 17'd0);
    // Index has not yet advanced for the word whose 4th byte is arriving
    assign w_last_word  = ((r_word_idx + 17'd1) == {1'b0, r_count});
    assign w_data_en    = w_accept && (r_state == c_st_data);
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign w_acc_en     = w_accept && ((r_state == c_st_hdr0) ||
                                       (r_state == c_st_hdr1) ||
                                       (r_state == c_st_data));
`endif

    imem_byte_assembler u_asm (
        .clk          (clk),
        .rst          (reset),
        .i_clear      (w_start_load),
        .i_data_en    (w_data_en),
        .i_byte       (bus.in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_last_byte  (w_last_byte)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .i_acc_en     (w_acc_en),
        .o_acc        (w_acc)
`endif
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_next = c_st_hdr0;
                end
            end
            c_st_hdr0: begin
                if (w_accept) begin
                    w_next = c_st_hdr1;
                end
            end
            c_st_hdr1: begin
                if (w_accept) begin
                    if (w_oversize) begin
                        w_next = c_st_done;
                    end else if (w_empty) begin
                        w_next = c_st_tail;
                    end else begin
                        w_next = c_st_data;
                    end
                end
            end
            c_st_data: begin
                if (w_accept && w_last_byte && w_last_word) begin
                    w_next = c_st_tail;
                end
            end
            c_st_fin: begin
                w_next = c_st_done;
            end
            c_st_chk: begin
                if (w_accept) begin
                    w_next = c_st_done;
                end
            end
            c_st_done: begin
                if (start) begin
                    w_next = c_st_hdr0;
                end
            end
            default: begin
                w_next = c_st_idle;
            end
        endcase
    end

    // State-derived handshake and status outputs
    always_comb begin
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        core_reset   = 1'b1;
        case (r_state)
            c_st_hdr0, c_st_hdr1, c_st_data, c_st_chk: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
            end
            c_st_fin: begin
                busy = 1'b1;
            end
            c_st_done: begin
                done       = 1'b1;
                core_reset = r_error;
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

    // Header capture of the word count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 16'd0;
        end else if (w_accept && (r_state == c_st_hdr0)) begin
            r_count[7:0] <= bus.in_data;
        end else if (w_accept && (r_state == c_st_hdr1)) begin
            r_count[15:8] <= bus.in_data;
        end
    end

    // Word index: advances on each memory write, restarts with each load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_idx <= 17'd0;
        end else if (w_start_load) begin
            r_word_idx <= 17'd0;
        end else if (w_word_valid) begin
            r_word_idx <= r_word_idx + 17'd1;
        end
    end

    // Sticky error flag: oversize count, or checksum mismatch when enabled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_start_load) begin
            r_error <= 1'b0;
        end else if (w_accept && (r_state == c_st_hdr1) && w_oversize) begin
            r_error <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        end else if (w_accept && (r_state == c_st_chk) && (bus.in_data != w_acc)) begin
            r_error <= 1'b1;
`endif
        end
    end

    assign error         = r_error;
    assign bus.mem_we    = w_word_valid;
    assign bus.mem_addr  = r_word_idx[ADDR_WIDTH-1:0];
    assign bus.mem_wdata = w_word;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Self-checking bench for imem_loader. Expected memory writes are
//            queued as image bytes are driven and compared as writes appear.
// Config   : IMEM_LOADER_CHECKSUM_EN selects the checksum-byte flow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_WIDTH = imem_loader_pkg::c_default_addr_width;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
    } wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic core_reset;
    logic busy;
    logic done;
    logic error;

    imem_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    imem_loader #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         n_wr  = 0;
    int         wr_base;
    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] img[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory-side scoreboard: every write must match the head of the queue
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("unexpected_we", 64'(bus.mem_addr), 64'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(bus.mem_addr), 64'(mon_e.addr));
                check("wr_data", 64'(bus.mem_wdata), 64'(mon_e.data));
            end
        end
    end

    task automatic set_img(input logic [79:0] v, input int n);
        img.delete();
        for (int i = 0; i < n; i++) begin
            img.push_back(v[8*(n-1-i) +: 8]);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte from a negedge; returns at the negedge after acceptance
    task automatic send_byte(input logic [7:0] b, output int waited);
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            check("ready_wait", 64'd0, 64'd1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_image(input int n_bytes, input int max_gap, input bit mid_start);
        logic [31:0] w;
        wr_t         e;
        int          addr;
        int          waited;
        addr = 0;
        for (int i = 0; i < n_bytes; i++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            end
            if (i >= 2 && ((i - 2) % 4) == 3) begin
                w      = {img[i], img[i-1], img[i-2], img[i-3]};
                e.addr = ADDR_WIDTH'(addr);
                e.data = w;
                exp_q.push_back(e);
                addr++;
            end
            send_byte(img[i], waited);
            if (max_gap == 0) begin
                check("no_stall", 64'(waited), 64'd0);
            end
            if (mid_start && i == 3) begin
                do_start();
            end
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    function automatic logic [7:0] img_xor();
        logic [7:0] x;
        x = 8'd0;
        foreach (img[i]) x ^= img[i];
        return x;
    endfunction
`endif

    // Closes a load that must succeed and checks the completion timing
    task automatic finish_ok(input bit has_data);
`ifdef IMEM_LOADER_CHECKSUM_EN
        int waited;
        send_byte(img_xor(), waited);
        check("chk_no_stall", 64'(waited), 64'd0);
`else
        check("fin_we", 64'(bus.mem_we), 64'(has_data));
        check("fin_done", 64'(done), 64'd0);
        check("fin_busy", 64'(busy), 64'd1);
        @(negedge clk);
`endif
        check("done", 64'(done), 64'd1);
        check("core_reset", 64'(core_reset), 64'd0);
        check("error", 64'(error), 64'd0);
        check("busy", 64'(busy), 64'd0);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_core_reset", 64'(core_reset), 64'd1);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Two-word image, back-to-back bytes
        set_img(80'h0200_1300_5000_9300_1000, 10);
        do_start();
        check("hdr0_ready", 64'(bus.in_ready), 64'd1);
        check("hdr0_core_reset", 64'(core_reset), 64'd1);
        wr_base = n_wr;
        send_image(img.size(), 0, 1'b0);
        finish_ok(1'b1);
        check("img_a_writes", 64'(n_wr - wr_base), 64'd2);

        // Empty image: count 0, reloaded from DONE
        set_img(80'h0000, 2);
        wr_base = n_wr;
        do_start();
        check("reload_core_reset", 64'(core_reset), 64'd1);
        check("reload_done", 64'(done), 64'd0);
        send_image(img.size(), 0, 1'b0);
        finish_ok(1'b0);
        check("empty_writes", 64'(n_wr - wr_base), 64'd0);

        // Oversize count 257 > 256 words
        set_img(80'h0101, 2);
        wr_base = n_wr;
        do_start();
        send_image(img.size(), 0, 1'b0);
        check("ovf_done", 64'(done), 64'd1);
        check("ovf_error", 64'(error), 64'd1);
        check("ovf_core_reset", 64'(core_reset), 64'd1);
        check("ovf_busy", 64'(busy), 64'd0);
        check("ovf_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (3) @(negedge clk);
        check("ovf_writes", 64'(n_wr - wr_base), 64'd0);

        // Same two-word image with random gaps and an ignored mid-load start
        set_img(80'h0200_1300_5000_9300_1000, 10);
        wr_base = n_wr;
        do_start();
        check("gap_error_cleared", 64'(error), 64'd0);
        send_image(img.size(), 3, 1'b1);
        finish_ok(1'b1);
        check("gap_writes", 64'(n_wr - wr_base), 64'd2);

        // Full-depth image: count == DEPTH is legal, last address 255
        img.delete();
        img.push_back(8'h00);
        img.push_back(8'h01);
        for (int i = 0; i < 256; i++) begin
            logic [31:0] rw;
            rw = $urandom();
            for (int k = 0; k < 4; k++) img.push_back(rw[8*k +: 8]);
        end
        wr_base = n_wr;
        do_start();
        send_image(img.size(), 0, 1'b0);
        finish_ok(1'b1);
        check("full_writes", 64'(n_wr - wr_base), 64'd256);

        // Reset after the 6th byte: only word 0 reaches memory
        set_img(80'h0200_1300_5000_9300_1000, 10);
        wr_base = n_wr;
        do_start();
        send_image(6, 0, 1'b0);
        check("rst_mid_we", 64'(bus.mem_we), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_core_reset", 64'(core_reset), 64'd1);
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        check("rst_mid_writes", 64'(n_wr - wr_base), 64'd1);
        check("rst_mid_sb_empty", 64'(exp_q.size()), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum: writes still land, core stays in reset
        set_img(80'h0200_1300_5000_9300_1000, 10);
        wr_base = n_wr;
        do_start();
        send_image(img.size(), 0, 1'b0);
        begin
            int waited;
            send_byte(img_xor() ^ 8'h01, waited);
        end
        check("badchk_done", 64'(done), 64'd1);
        check("badchk_error", 64'(error), 64'd1);
        check("badchk_core_reset", 64'(core_reset), 64'd1);
        check("badchk_writes", 64'(n_wr - wr_base), 64'd2);
`endif

        // Recovery load after reset / error
        set_img(80'h0200_1300_5000_9300_1000, 10);
        wr_base = n_wr;
        do_start();
        send_image(img.size(), 0, 1'b0);
        finish_ok(1'b1);
        check("final_writes", 64'(n_wr - wr_base), 64'd2);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Run-time bound
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
